// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } seq_state_t;

  localparam int PC_W_DEFAULT      = 8;
  localparam int RAS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: LIFO with occupancy count and full/empty flags.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx, top_idx;

  // When full, the low bits of count wrap to 0, so top_idx still lands on DEPTH-1.
  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      count_d       = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC jump/hold sequencer: branch, call/return via RAS, halt, and flush bubble.
//   state | meaning
//   IDLE  | waiting for start, PC frozen
//   RUN   | decoding, instructions commit
//   FLUSH | one-cycle bubble after a taken transfer
//   HALT  | stopped by halt instruction until reset
//   FAULT | RAS overflow/underflow, frozen until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PC_W-1:0]             pc,
  input  logic                        is_branch,
  input  logic                        is_call,
  input  logic                        is_ret,
  input  logic                        is_halt,
  input  logic                        cond,
  input  logic [PC_W-1:0]             target,
  output logic                        jump_en,
  output logic [PC_W-1:0]             jump_target,
  output logic                        pc_hold,
  output logic                        instr_valid,
  output logic                        halted,
  output logic                        fault,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);
  seq_state_t      state_q, state_d;
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0] ras_top, ret_addr;

  assign ret_addr = pc + PC_W'(1);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (ret_addr),
    .dout  (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (is_halt)                       state_d = HALT;
        else if (is_ret)                   state_d = ras_empty ? FAULT : FLUSH;
        else if (is_call)                  state_d = ras_full  ? FAULT : FLUSH;
        else if (is_branch && cond)        state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      HALT:  state_d = HALT;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    jump_en     = 1'b0;
    jump_target = '0;
    pc_hold     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    case (state_q)
      IDLE: pc_hold = 1'b1;
      RUN: begin
        instr_valid = 1'b1;
        if (is_halt) begin
          pc_hold = 1'b1;
        end else if (is_ret) begin
          if (ras_empty) begin
            pc_hold     = 1'b1;
            instr_valid = 1'b0;
          end else begin
            jump_en     = 1'b1;
            jump_target = ras_top;
            ras_pop     = 1'b1;
          end
        end else if (is_call) begin
          if (ras_full) begin
            pc_hold     = 1'b1;
            instr_valid = 1'b0;
          end else begin
            jump_en     = 1'b1;
            jump_target = target;
            ras_push    = 1'b1;
          end
        end else if (is_branch && cond) begin
          jump_en     = 1'b1;
          jump_target = target;
        end
      end
      FLUSH: ;
      HALT: begin
        pc_hold = 1'b1;
        halted  = 1'b1;
      end
      FAULT: begin
        pc_hold = 1'b1;
        fault   = 1'b1;
      end
      default: pc_hold = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; ctl = {jump_en, pc_hold, instr_valid, halted, fault}.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, is_branch, is_call, is_ret, is_halt, cond;
  logic [7:0] pc, target;
  logic       jump_en, pc_hold, instr_valid, halted, fault;
  logic [7:0] jump_target;
  logic [2:0] ras_count;
  logic [4:0] ctl;
  int errors = 0;
  int checks = 0;

  assign ctl = {jump_en, pc_hold, instr_valid, halted, fault};

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(8), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .is_branch(is_branch), .is_call(is_call), .is_ret(is_ret), .is_halt(is_halt),
    .cond(cond), .target(target), .jump_en(jump_en), .jump_target(jump_target),
    .pc_hold(pc_hold), .instr_valid(instr_valid), .halted(halted), .fault(fault),
    .ras_count(ras_count)
  );

  task automatic clr();
    is_branch = 0; is_call = 0; is_ret = 0; is_halt = 0; cond = 0;
    pc = 8'h00; target = 8'h00;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  task automatic reset_start();
    @(negedge clk); clr(); start = 0; reset = 0;
    @(negedge clk); reset = 1; start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic test_reset();
    reset = 0; start = 0; clr();
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b01000); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL reset_jt got=%h exp=00", jump_target); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_ras got=%0d exp=0", ras_count); end
  endtask

  task automatic test_start();
    reset = 1; nxt(); #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL idle_wait_ctl got=%b exp=%b", ctl, 5'b01000); end
    start = 1; #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL idle_start_ctl got=%b exp=%b", ctl, 5'b01000); end
    nxt(); start = 0; #1;
    checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL run_ctl got=%b exp=%b", ctl, 5'b00100); end
  endtask

  task automatic test_branch();
    is_branch = 1; cond = 1; target = 8'h40; #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL br_taken_ctl got=%b exp=%b", ctl, 5'b10100); end
    checks++; if (jump_target !== 8'h40) begin errors++; $display("FAIL br_taken_jt got=%h exp=40", jump_target); end
    nxt(); #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL br_flush_ctl got=%b exp=%b", ctl, 5'b00000); end
    nxt(); #1;
    checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL br_rerun_ctl got=%b exp=%b", ctl, 5'b00100); end
    is_branch = 1; cond = 0; target = 8'h40; #1;
    checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL br_not_ctl got=%b exp=%b", ctl, 5'b00100); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL br_not_jt got=%h exp=00", jump_target); end
    nxt(); #1;
    checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL br_not_stay got=%b exp=%b", ctl, 5'b00100); end
  endtask

  task automatic test_call_ret();
    pc = 8'h10; is_call = 1; target = 8'h80; #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL call_ctl got=%b exp=%b", ctl, 5'b10100); end
    checks++; if (jump_target !== 8'h80) begin errors++; $display("FAIL call_jt got=%h exp=80", jump_target); end
    nxt(); #1;
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL call_ras got=%0d exp=1", ras_count); end
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL call_flush got=%b exp=%b", ctl, 5'b00000); end
    nxt(); is_ret = 1; #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL ret_ctl got=%b exp=%b", ctl, 5'b10100); end
    checks++; if (jump_target !== 8'h11) begin errors++; $display("FAIL ret_jt got=%h exp=11", jump_target); end
    nxt(); #1;
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL ret_ras got=%0d exp=0", ras_count); end
    nxt();
  endtask

  task automatic test_wrap();
    pc = 8'hFF; is_call = 1; target = 8'h20;
    nxt(); nxt(); is_ret = 1; #1;
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL wrap_jt got=%h exp=00", jump_target); end
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL wrap_je got=%b exp=1", jump_en); end
    nxt(); nxt();
  endtask

  task automatic test_flush_ignore();
    pc = 8'h30; is_call = 1; target = 8'h50;
    nxt(); pc = 8'h31; is_call = 1; target = 8'h55; is_branch = 1; cond = 1; #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL flush_ign_ctl got=%b exp=%b", ctl, 5'b00000); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL flush_ign_jt got=%h exp=00", jump_target); end
    nxt(); #1;
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL flush_ign_ras got=%0d exp=1", ras_count); end
    is_ret = 1; #1;
    checks++; if (jump_target !== 8'h31) begin errors++; $display("FAIL flush_ign_ret got=%h exp=31", jump_target); end
    nxt(); nxt();
  endtask

  task automatic test_lifo();
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i + 1); is_call = 1; target = 8'h90;
      nxt(); nxt();
    end
    #1;
    checks++; if (ras_count !== 3'd3) begin errors++; $display("FAIL lifo_ras got=%0d exp=3", ras_count); end
    for (int i = 0; i < 3; i++) begin
      is_ret = 1; #1;
      checks++; if (jump_target !== 8'(4 - i)) begin errors++; $display("FAIL lifo_ret%0d got=%h exp=%h", i, jump_target, 8'(4 - i)); end
      nxt(); nxt();
    end
    #1;
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL lifo_empty got=%0d exp=0", ras_count); end
  endtask

  task automatic test_overflow();
    reset_start();
    for (int i = 0; i < 4; i++) begin
      pc = 8'(8'h20 + i); is_call = 1; target = 8'h60;
      nxt(); nxt();
    end
    #1;
    checks++; if (ras_count !== 3'd4) begin errors++; $display("FAIL ovf_full got=%0d exp=4", ras_count); end
    pc = 8'h50; is_call = 1; target = 8'h60; #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL ovf_call_ctl got=%b exp=%b", ctl, 5'b01000); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL ovf_call_jt got=%h exp=00", jump_target); end
    nxt(); #1;
    checks++; if (ctl !== 5'b01001) begin errors++; $display("FAIL ovf_fault got=%b exp=%b", ctl, 5'b01001); end
    is_ret = 1; start = 1; #1;
    checks++; if (ctl !== 5'b01001) begin errors++; $display("FAIL ovf_fault_ret got=%b exp=%b", ctl, 5'b01001); end
    nxt(); start = 0; #1;
    checks++; if (ctl !== 5'b01001) begin errors++; $display("FAIL ovf_persist got=%b exp=%b", ctl, 5'b01001); end
    checks++; if (ras_count !== 3'd4) begin errors++; $display("FAIL ovf_frozen got=%0d exp=4", ras_count); end
  endtask

  task automatic test_underflow();
    reset_start();
    is_ret = 1; #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL unf_ctl got=%b exp=%b", ctl, 5'b01000); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL unf_jt got=%h exp=00", jump_target); end
    nxt(); #1;
    checks++; if (ctl !== 5'b01001) begin errors++; $display("FAIL unf_fault got=%b exp=%b", ctl, 5'b01001); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL unf_ras got=%0d exp=0", ras_count); end
  endtask

  task automatic test_halt_priority();
    reset_start();
    pc = 8'h05; is_halt = 1; is_call = 1; is_ret = 1; target = 8'h70; #1;
    checks++; if (ctl !== 5'b01100) begin errors++; $display("FAIL halt_dec_ctl got=%b exp=%b", ctl, 5'b01100); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL halt_dec_jt got=%h exp=00", jump_target); end
    nxt(); #1;
    checks++; if (ctl !== 5'b01010) begin errors++; $display("FAIL halt_state got=%b exp=%b", ctl, 5'b01010); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL halt_nopush got=%0d exp=0", ras_count); end
    start = 1; nxt(); nxt(); start = 0; #1;
    checks++; if (ctl !== 5'b01010) begin errors++; $display("FAIL halt_start_ign got=%b exp=%b", ctl, 5'b01010); end
  endtask

  task automatic test_flush_reset();
    reset_start();
    pc = 8'h40; is_call = 1; target = 8'h10;
    nxt(); #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL frst_flush got=%b exp=%b", ctl, 5'b00000); end
    reset = 0; is_branch = 1; cond = 1; target = 8'h33;
    nxt(); reset = 1; #1;
    checks++; if (ctl !== 5'b01000) begin errors++; $display("FAIL frst_idle got=%b exp=%b", ctl, 5'b01000); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL frst_ras got=%0d exp=0", ras_count); end
    checks++; if (jump_target !== 8'h00) begin errors++; $display("FAIL frst_jt got=%h exp=00", jump_target); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_branch();
    test_call_ret();
    test_wrap();
    test_flush_ignore();
    test_lifo();
    test_overflow();
    test_underflow();
    test_halt_priority();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control block that drives the program counter's jump interface and hold request from decoded instruction fields. Resolves conditional branches, subroutine call/return through a small return-address stack (RAS), start/halt, and a one-cycle flush bubble after every taken control transfer. Sits between the decoder and the PC register. Also gates instruction validity for downstream execute logic.

Parameters:
PC_W, 8, program counter / target width
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous active-low reset; reset==0 at posedge clears all state
start  input  1  leave IDLE and begin execution
pc  input  PC_W  current PC value, the address of the instruction being decoded
is_branch  input  1  decoded conditional branch
is_call  input  1  decoded call
is_ret  input  1  decoded return
is_halt  input  1  decoded halt
cond  input  1  branch condition flag; branch taken when 1
target  input  PC_W  branch/call destination
jump_en  output  1  to PC: load jump_target this edge
jump_target  output  PC_W  to PC: load value
pc_hold  output  1  to PC: freeze PC this cycle
instr_valid  output  1  decoded instruction may commit
halted  output  1  in HALT state
fault  output  1  in FAULT state (RAS overflow/underflow)
ras_count  output  $clog2(RAS_DEPTH)+1  current RAS occupancy

Behaviour:
- States: IDLE, RUN, FLUSH, HALT, FAULT. Registered state. Outputs are combinational from the state and the current inputs (Mealy).
- Reset (reset==0 at posedge): state=IDLE; RAS empty; ras_count=0. In IDLE: pc_hold=1, jump_en=0, instr_valid=0, halted=0, fault=0, jump_target=0.
- IDLE: if start, go to RUN next cycle; otherwise remain in IDLE.
- RUN: instr_valid=1. Decode priority is halt > ret > call > branch; lower-priority bits are ignored when several are set.
  - halt: pc_hold=1, no jump, next state HALT.
  - ret, RAS non-empty: jump_en=1, jump_target=RAS top, pop, next state FLUSH.
  - ret, RAS empty: no jump, no pop, pc_hold=1, instr_valid=0, next state FAULT.
  - call, RAS not full: push (pc+1) mod 2^PC_W, jump_en=1, jump_target=target, next state FLUSH.
  - call, RAS full: no push, no jump, pc_hold=1, instr_valid=0, next state FAULT.
  - branch with cond=1: jump_en=1, jump_target=target, next state FLUSH.
  - branch with cond=0, or no decode bit set: jump_en=0, pc_hold=0 (PC increments), stay in RUN.
- FLUSH: exactly one cycle. instr_valid=0, all decode inputs ignored, jump_en=0, pc_hold=0, next state RUN.
- HALT: pc_hold=1, halted=1, instr_valid=0. Terminal until reset; start is ignored.
- FAULT: pc_hold=1, fault=1, instr_valid=0. Terminal until reset; RAS contents are frozen.
- jump_target=0 whenever jump_en=0.
- pc+1 wraps: 0xFF+1 = 0x00.
- RAS is LIFO. ras_count ranges 0..RAS_DEPTH. A push and a pop never occur in the same cycle.
- Reset overrides every state, including FLUSH and a pending jump.

Decomposition:
- Shared package pc_seq_pkg: state enum seq_state_t {IDLE, RUN, FLUSH, HALT, FAULT}, constants PC_W_DEFAULT and RAS_DEPTH_DEFAULT.
- One sub-module, ras_stack: push, pop, data in/out, count, full, empty, with synchronous active-low reset.
- The FSM and decode priority stay in pc_sequencer.

Test Plan:
- Reset low, then start=1 one cycle -> pc_hold=1 while in IDLE; RUN next cycle with instr_valid=1, pc_hold=0.
- RUN, is_branch=1, cond=1, target=0x40 -> jump_en=1, jump_target=0x40 that cycle; next cycle FLUSH with instr_valid=0; RUN after. Repeat with cond=0 -> jump_en=0, stay in RUN.
- pc=0x10, is_call=1, target=0x80 -> push 0x11, jump to 0x80, ras_count=1. Later is_ret=1 -> jump_target=0x11, ras_count=0.
- pc=0xFF, call -> pushed value 0x00. Five nested calls with RAS_DEPTH=4 -> fifth call gives jump_en=0, then fault=1 and pc_hold=1 persistently.
- is_ret=1 with RAS empty -> FAULT, no jump. is_halt=1 together with is_call=1 -> halt wins, no push, halted=1; start ignored afterwards.
- In FLUSH, drive is_call=1 -> ignored, ras_count unchanged. Reset low during FLUSH -> IDLE, ras_count=0.
